// File: rtl/scr1_dma_pkg.sv
// -----------------------------------------------------------------------------
// scr1_dma_pkg
//   Types and constants local to the single-channel dmem word-copy engine.
//   - type_scr1_dma_state_e : copy FSM states
//   - SCR1_DMA_WORD_BYTES   : pointer increment per copied word
//   - scr1_dma_misaligned() : word-alignment test on the low address bits
// -----------------------------------------------------------------------------
package scr1_dma_pkg;

    typedef enum logic [2:0] {
        SCR1_DMA_IDLE    = 3'd0,
        SCR1_DMA_RD_REQ  = 3'd1,
        SCR1_DMA_RD_WAIT = 3'd2,
        SCR1_DMA_WR_REQ  = 3'd3,
        SCR1_DMA_WR_WAIT = 3'd4
    } type_scr1_dma_state_e;

    localparam int unsigned SCR1_DMA_WORD_BYTES = 4;

    // Only word transfers are issued, so any set low bit is an error.
    function automatic logic scr1_dma_misaligned(input logic [1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage : scr1_dma_pkg

// File: rtl/scr1_memif_pkg.sv
// -----------------------------------------------------------------------------
// scr1_memif_pkg
//   SCR1 memory-interface types shared by every dmem/imem initiator and
//   responder: request command, access width and response code.
//   Encodings match the core's memif definitions so blocks built against
//   either copy interoperate on the same bus.
// -----------------------------------------------------------------------------
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_dma_copy.sv
// -----------------------------------------------------------------------------
// scr1_dma_copy
//   Single-channel word-copy engine. Reads a word from src, writes it to dst,
//   advances both pointers by one word and repeats for len words. Acts as an
//   initiator on the SCR1 dmem request/response interface with exactly one
//   transaction outstanding.
//
// Ports
//   clk, rst        : block clock, asynchronous active-high reset
//   start           : one-cycle command strobe, ignored unless idle
//   abort           : level; stop after the word in progress is written
//   src_addr/dst_addr/len : job parameters, sampled on an accepted start
//   busy            : job in progress (drops in the done/err pulse cycle)
//   done / err      : one-cycle completion / error pulses
//   err_addr        : address of the most recent error (sticky)
//   words_done      : words fully written since the last accepted start
//   dmem_*          : SCR1 dmem initiator port (req/cmd/width/addr/wdata out,
//                     req_ack/rdata/resp in)
//
// Timing with a zero-wait responder: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT per
// word, i.e. 4 cycles/word; done/err appear the cycle after the last response.
// -----------------------------------------------------------------------------
module scr1_dma_copy
    import scr1_memif_pkg::*;
    import scr1_dma_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    // Command / status
    input  logic                 start,
    input  logic                 abort,
    input  logic [AWIDTH-1:0]    src_addr,
    input  logic [AWIDTH-1:0]    dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AWIDTH-1:0]    err_addr,
    output logic [LEN_WIDTH-1:0] words_done,

    // dmem initiator
    output logic                 dmem_req,
    output type_scr1_mem_cmd_e   dmem_cmd,
    output type_scr1_mem_width_e dmem_width,
    output logic [AWIDTH-1:0]    dmem_addr,
    output logic [DWIDTH-1:0]    dmem_wdata,
    input  logic                 dmem_req_ack,
    input  logic [DWIDTH-1:0]    dmem_rdata,
    input  type_scr1_mem_resp_e  dmem_resp
);

    type_scr1_dma_state_e  state;
    logic [AWIDTH-1:0]     src_ptr;
    logic [AWIDTH-1:0]     dst_ptr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DWIDTH-1:0]     data_buf;
    // Sticky: abort was high at some point during the current word.
    logic                  abort_seen;

    logic [AWIDTH-1:0]     src_nxt;
    logic [AWIDTH-1:0]     dst_nxt;
    logic                  last_word;

    assign src_nxt    = src_ptr + AWIDTH'(SCR1_DMA_WORD_BYTES);
    assign dst_nxt    = dst_ptr + AWIDTH'(SCR1_DMA_WORD_BYTES);
    assign last_word  = (remaining == LEN_WIDTH'(1));

    // Only word accesses are ever issued.
    assign dmem_width = SCR1_MEM_WIDTH_WORD;
    // The write-data register doubles as the read capture buffer.
    assign dmem_wdata = data_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCR1_DMA_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
            words_done <= '0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= SCR1_MEM_CMD_RD;
            dmem_addr  <= '0;
            data_buf   <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            abort_seen <= 1'b0;
        end else begin
            // Pulses default low; set only in the cycle that ends a job.
            done <= 1'b0;
            err  <= 1'b0;

            if ((state != SCR1_DMA_IDLE) && abort) begin
                abort_seen <= 1'b1;
            end

            case (state)
                SCR1_DMA_IDLE: begin
                    if (start) begin
                        src_ptr    <= src_addr;
                        dst_ptr    <= dst_addr;
                        remaining  <= len;
                        words_done <= '0;
                        abort_seen <= 1'b0;
                        // Alignment faults and empty jobs finish without
                        // touching the bus; src is reported before dst.
                        if (scr1_dma_misaligned(src_addr[1:0])) begin
                            err      <= 1'b1;
                            err_addr <= src_addr;
                        end else if (scr1_dma_misaligned(dst_addr[1:0])) begin
                            err      <= 1'b1;
                            err_addr <= dst_addr;
                        end else if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            state     <= SCR1_DMA_RD_REQ;
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= SCR1_MEM_CMD_RD;
                            dmem_addr <= src_addr;
                        end
                    end
                end

                // Request fields are registers and only change on ack,
                // which keeps them stable while the responder stalls.
                SCR1_DMA_RD_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req <= 1'b0;
                        state    <= SCR1_DMA_RD_WAIT;
                    end
                end

                SCR1_DMA_RD_WAIT: begin
                    case (dmem_resp)
                        SCR1_MEM_RESP_RDY_OK: begin
                            data_buf  <= dmem_rdata;
                            state     <= SCR1_DMA_WR_REQ;
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= SCR1_MEM_CMD_WR;
                            dmem_addr <= dst_ptr;
                        end
                        SCR1_MEM_RESP_RDY_ER: begin
                            err      <= 1'b1;
                            err_addr <= src_ptr;
                            busy     <= 1'b0;
                            state    <= SCR1_DMA_IDLE;
                        end
                        default: ;
                    endcase
                end

                SCR1_DMA_WR_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req <= 1'b0;
                        state    <= SCR1_DMA_WR_WAIT;
                    end
                end

                SCR1_DMA_WR_WAIT: begin
                    case (dmem_resp)
                        SCR1_MEM_RESP_RDY_OK: begin
                            src_ptr    <= src_nxt;
                            dst_ptr    <= dst_nxt;
                            words_done <= words_done + LEN_WIDTH'(1);
                            remaining  <= remaining - LEN_WIDTH'(1);
                            // Abort in this very cycle also counts.
                            if (last_word || abort_seen || abort) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= SCR1_DMA_IDLE;
                            end else begin
                                abort_seen <= 1'b0;
                                state      <= SCR1_DMA_RD_REQ;
                                dmem_req   <= 1'b1;
                                dmem_cmd   <= SCR1_MEM_CMD_RD;
                                dmem_addr  <= src_nxt;
                            end
                        end
                        SCR1_MEM_RESP_RDY_ER: begin
                            err      <= 1'b1;
                            err_addr <= dst_ptr;
                            busy     <= 1'b0;
                            state    <= SCR1_DMA_IDLE;
                        end
                        default: ;
                    endcase
                end

                default: begin
                    state    <= SCR1_DMA_IDLE;
                    busy     <= 1'b0;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : scr1_dma_copy

// File: doc/scr1_dma_copy.md
Name: scr1_dma_copy

Overview:
- Single-channel word-copy engine acting as an initiator (master) on the SCR1 dmem request/response interface.
- Reads one word from a source address, writes it to a destination address, and repeats for a programmed word count.
- Started by a local command port from an owning controller. Drives any dmem responder, e.g. timer, TCM, or a bridge to external memory.
- Keeps one transaction outstanding at a time.

Parameters:
- AWIDTH, 32, dmem address width (equals `SCR1_DMEM_AWIDTH).
- DWIDTH, 32, dmem data width (equals `SCR1_DMEM_DWIDTH).
- LEN_WIDTH, 16, width of the word-count and progress counters.

Ports:
- clk  in  1  block clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- abort  in  1  level; requests early stop after the current word completes.
- src_addr  in  AWIDTH  source byte address, sampled on accepted start.
- dst_addr  in  AWIDTH  destination byte address, sampled on accepted start.
- len  in  LEN_WIDTH  word count, sampled on accepted start.
- busy  out  1  high from the accepted start until the cycle before done or err pulses.
- done  out  1  one-cycle pulse on normal completion or on abort completion.
- err  out  1  one-cycle pulse on error.
- err_addr  out  AWIDTH  address that caused the last error; holds until the next error.
- words_done  out  LEN_WIDTH  count of words fully written since the last accepted start.
- dmem_req  out  1  request valid.
- dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD or SCR1_MEM_CMD_WR.
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD.
- dmem_addr  out  AWIDTH  request address.
- dmem_wdata  out  DWIDTH  write data.
- dmem_req_ack  in  1  request accepted by the responder.
- dmem_rdata  in  DWIDTH  read data, valid with SCR1_MEM_RESP_RDY_OK.
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY, RDY_OK or RDY_ER.

Behaviour:
- Reset values:
  - state IDLE.
  - busy, done, err, dmem_req = 0.
  - dmem_cmd = RD; dmem_width = WORD.
  - dmem_addr, dmem_wdata, err_addr, words_done = 0.
  - Reset asserted mid-transfer drops dmem_req immediately. Any response still in flight is discarded.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE, on start:
  - Latch src_ptr, dst_ptr, and remaining=len. Clear words_done.
  - src_addr[1:0]!=0 or dst_addr[1:0]!=0 -> err pulse next cycle, err_addr = the offending address (src checked first). No dmem request is issued.
  - len==0 -> done pulse next cycle, no dmem request.
  - Otherwise busy=1 and go to RD_REQ.
- RD_REQ:
  - dmem_req=1, cmd=RD, addr=src_ptr.
  - req, cmd, addr and wdata stay stable until dmem_req_ack=1; on ack go to RD_WAIT.
- RD_WAIT:
  - dmem_req=0. dmem_resp is sampled only in WAIT states; a response coincident with ack is not used.
  - NOTRDY -> stay.
  - RDY_OK -> capture dmem_rdata into data_buf, go to WR_REQ.
  - RDY_ER -> err pulse, err_addr=src_ptr, go to IDLE.
- WR_REQ:
  - dmem_req=1, cmd=WR, addr=dst_ptr, wdata=data_buf.
  - Held stable until ack; on ack go to WR_WAIT.
- WR_WAIT:
  - NOTRDY -> stay.
  - RDY_ER -> err pulse, err_addr=dst_ptr, go to IDLE; words_done not incremented.
  - RDY_OK -> src_ptr+=4, dst_ptr+=4, words_done+=1, remaining-=1.
    - If remaining was 1, or abort was seen high at any point since RD_REQ of this word: done pulse, go to IDLE.
    - Otherwise go to RD_REQ.
- done/err timing: they pulse in the cycle after the final response; busy deasserts in that same cycle.
- Pointer arithmetic is modulo 2^AWIDTH and wraps silently. Ranges always copy in ascending order; overlap is not detected.
- Throughput: 4 cycles per word with a zero-wait responder (ack same cycle, response next cycle).
- A start arriving in the done or err pulse cycle is accepted, since the state is already IDLE.

Decomposition:
- Reuse type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e from the existing memif package.
- Add type_scr1_dma_state_e and the address increment constant SCR1_DMA_WORD_BYTES=4 to a small scr1_dma_pkg.
- No sub-module; a single FSM plus datapath is natural.

Test Plan:
- Zero-wait responder (ack=1, OK next cycle), src=0x100 holding {A,B,C}, dst=0x200, len=3, start at cycle 0 -> 6 requests alternating RD/WR; done pulse at cycle 13; dst holds {A,B,C}; words_done=3.
- len=0 -> done at cycle 1, dmem_req never asserted, words_done=0.
- src=0x102 -> err at cycle 1, err_addr=0x102, no request issued.
- Responder returns RDY_ER on the read of 0x104 -> err, err_addr=0x104, words_done=1, no write to 0x204.
- req_ack held low 3 cycles on each request -> dmem_req, addr, cmd, wdata stable all 3 cycles; data is still copied correctly.
- abort pulsed during the second read of a len=5 copy -> second write completes, done pulses, words_done=2; then assert rst mid-transfer -> dmem_req=0 and busy=0 immediately.
